// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// request, and fills the IF/ID pipeline register. A one-entry holding
// buffer keeps a word that arrived while decode was stalled, so the
// memory is not asked for it a second time.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        J,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpIndex,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid,
  output logic [5:0]  OP
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetchState_t;

  fetchState_t stateReg;
  logic [31:0] pcReg;
  logic [31:0] holdBufReg;
  logic [31:0] ifidInstrReg;
  logic [31:0] ifidPc4Reg;
  logic        ifidValidReg;
  logic        imemReqReg;

  logic        redirect;
  logic [31:0] jumpTarget;
  logic [31:0] branchTarget;
  logic [31:0] redirectTarget;
  logic [31:0] pcPlus4;

  // Redirect decode and target selection; a jump outranks a taken branch.
  always_comb begin
    redirect       = J | (Branch & Zero);
    jumpTarget     = {ifidPc4Reg[31:28], JumpIndex, 2'b00};
    branchTarget   = ifidPc4Reg + {BranchOffset[29:0], 2'b00};
    redirectTarget = J ? jumpTarget : branchTarget;
    pcPlus4        = pcReg + 32'd4;
  end

  // PC, IF/ID register, holding buffer and fetch FSM; the request output is
  // registered alongside the state so it is high exactly while in FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg     <= BOOT;
      pcReg        <= RESET_PC;
      holdBufReg   <= 32'd0;
      ifidInstrReg <= 32'd0;
      ifidPc4Reg   <= 32'd0;
      ifidValidReg <= 1'b0;
      imemReqReg   <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over stall and memory readiness in every state.
      pcReg        <= redirectTarget;
      ifidValidReg <= 1'b0;
      holdBufReg   <= 32'd0;
      stateReg     <= FETCH;
      imemReqReg   <= 1'b1;
    end else begin
      case (stateReg)
        BOOT: begin
          stateReg   <= FETCH;
          imemReqReg <= 1'b1;
        end
        FETCH: begin
          if (imem_ready && !Stall) begin
            ifidInstrReg <= imem_rdata;
            ifidPc4Reg   <= pcPlus4;
            ifidValidReg <= 1'b1;
            pcReg        <= pcPlus4;
          end else if (imem_ready && Stall) begin
            // Park the word; decode cannot take it yet.
            holdBufReg <= imem_rdata;
            stateReg   <= HOLD;
            imemReqReg <= 1'b0;
          end else if (!Stall) begin
            // Memory not ready: insert a bubble, keep asking for the same PC.
            ifidValidReg <= 1'b0;
          end
        end
        HOLD: begin
          if (!Stall) begin
            ifidInstrReg <= holdBufReg;
            ifidPc4Reg   <= pcPlus4;
            ifidValidReg <= 1'b1;
            pcReg        <= pcPlus4;
            stateReg     <= FETCH;
            imemReqReg   <= 1'b1;
          end
        end
        default: begin
          stateReg   <= BOOT;
          imemReqReg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = imemReqReg;
  assign imem_addr  = {pcReg[31:2], 2'b00};
  assign IFID_Instr = ifidInstrReg;
  assign IFID_PC4   = ifidPc4Reg;
  assign IFID_Valid = ifidValidReg;
  assign OP         = ifidInstrReg[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (RESET_PC = 0 and 0xFFFFFFFC) share
// the control inputs; each has its own memory responder. A transaction-level
// reference model predicts every output after every clock edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall, Branch, Zero, J, imemReady;
  logic [31:0] BranchOffset;
  logic [25:0] JumpIndex;
  logic [31:0] rdata0, rdata1;

  logic        req0, req1, valid0, valid1;
  logic [31:0] addr0, addr1, instr0, instr1, pc40, pc41;
  logic [5:0]  op0, op1;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Branch(Branch), .Zero(Zero),
    .J(J), .BranchOffset(BranchOffset), .JumpIndex(JumpIndex),
    .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0), .imem_ready(imemReady),
    .IFID_Instr(instr0), .IFID_PC4(pc40), .IFID_Valid(valid0), .OP(op0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Branch(Branch), .Zero(Zero),
    .J(J), .BranchOffset(BranchOffset), .JumpIndex(JumpIndex),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1), .imem_ready(imemReady),
    .IFID_Instr(instr1), .IFID_PC4(pc41), .IFID_Valid(valid1), .OP(op1)
  );

  // Instruction memory contents: a fixed word at 0, a scrambled address elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model, per instance: program counter, delivered IF/ID contents,
  // whether a first idle cycle after reset is pending, and whether a word
  // fetched under stall is still waiting to be handed to decode.
  logic [31:0] resetPc [2];
  logic [31:0] mPc [2], mInstr [2], mPc4 [2], mBuf [2];
  logic        mValid [2], mFirstIdle [2], mWaiting [2];

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] tgt;
      tgt = J ? {mPc4[k][31:28], JumpIndex, 2'b00}
              : mPc4[k] + BranchOffset * 32'd4;
      if (!rst_n) begin
        mPc[k] = resetPc[k]; mInstr[k] = 0; mPc4[k] = 0; mValid[k] = 0;
        mBuf[k] = 0; mFirstIdle[k] = 1; mWaiting[k] = 0;
      end else if (J || (Branch && Zero)) begin
        mPc[k] = tgt; mValid[k] = 0; mWaiting[k] = 0; mFirstIdle[k] = 0;
      end else if (mFirstIdle[k]) begin
        mFirstIdle[k] = 0;
      end else if (mWaiting[k]) begin
        if (!Stall) begin
          mInstr[k] = mBuf[k]; mPc4[k] = mPc[k] + 4; mValid[k] = 1;
          mPc[k] = mPc[k] + 4; mWaiting[k] = 0;
        end
      end else if (imemReady) begin
        if (Stall) begin
          mBuf[k] = memWord(mPc[k]); mWaiting[k] = 1;
        end else begin
          mInstr[k] = memWord(mPc[k]); mPc4[k] = mPc[k] + 4; mValid[k] = 1;
          mPc[k] = mPc[k] + 4;
        end
      end else if (!Stall) begin
        mValid[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic checkAll();
    chk("req0",   32'(req0),   32'(!mFirstIdle[0] && !mWaiting[0]));
    chk("addr0",  addr0,       mPc[0]);
    chk("instr0", instr0,      mInstr[0]);
    chk("pc4_0",  pc40,        mPc4[0]);
    chk("valid0", 32'(valid0), 32'(mValid[0]));
    chk("op0",    32'(op0),    32'(mInstr[0][31:26]));
    chk("req1",   32'(req1),   32'(!mFirstIdle[1] && !mWaiting[1]));
    chk("addr1",  addr1,       mPc[1]);
    chk("instr1", instr1,      mInstr[1]);
    chk("pc4_1",  pc41,        mPc4[1]);
    chk("valid1", 32'(valid1), 32'(mValid[1]));
    chk("op1",    32'(op1),    32'(mInstr[1][31:26]));
  endtask

  // One clock: memory answers the current address, edge, model update, check.
  task automatic tick();
    rdata0 = memWord(addr0);
    rdata1 = memWord(addr1);
    @(posedge clk);
    modelStep();
    #1;
    cycle++;
    checkAll();
    $display("cyc %0d rst_n=%b stall=%b rdy=%b J=%b BZ=%b%b | addr0=%h v0=%b pc4_0=%h | addr1=%h v1=%b pc4_1=%h",
             cycle, rst_n, Stall, imemReady, J, Branch, Zero, addr0, valid0, pc40, addr1, valid1, pc41);
  endtask

  initial begin
    resetPc[0] = 32'h0000_0000;
    resetPc[1] = 32'hFFFF_FFFC;
    for (int k = 0; k < 2; k++) begin
      mPc[k] = 0; mInstr[k] = 0; mPc4[k] = 0; mBuf[k] = 0;
      mValid[k] = 0; mFirstIdle[k] = 1; mWaiting[k] = 0;
    end
    rst_n = 0; Stall = 0; Branch = 0; Zero = 0; J = 0; imemReady = 1;
    BranchOffset = 0; JumpIndex = 0; rdata0 = 0; rdata1 = 0;

    // Reset state
    tick(); tick();
    chk("rst_addr0", addr0, 32'h0);
    chk("rst_addr1", addr1, 32'hFFFF_FFFC);
    chk("rst_req0", 32'(req0), 32'd0);
    chk("rst_op0", 32'(op0), 32'd0);

    // Boot cycle, then zero-wait fetches
    rst_n = 1;
    tick();
    chk("boot_valid0", 32'(valid0), 32'd0);
    chk("boot_req0", 32'(req0), 32'd1);
    tick();
    chk("first_instr0", instr0, 32'h2008_0005);
    chk("first_pc4_0", pc40, 32'h4);
    chk("first_op0", 32'(op0), 32'h08);
    chk("first_valid0", 32'(valid0), 32'd1);
    chk("wrap_pc4_1", pc41, 32'h0);
    chk("wrap_addr1", addr1, 32'h0);
    tick();
    chk("seq_addr0", addr0, 32'h8);

    // Memory wait at PC=8
    imemReady = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_valid0", 32'(valid0), 32'd0);
      chk("wait_addr0", addr0, 32'h8);
    end
    imemReady = 1;
    tick();
    chk("after_wait_pc4", pc40, 32'hC);
    chk("after_wait_instr", instr0, memWord(32'h8));

    // Stall as the word for 0x10 arrives, held two cycles
    tick();
    chk("pre_stall_addr", addr0, 32'h10);
    Stall = 1;
    tick();
    chk("hold_req0", 32'(req0), 32'd0);
    chk("hold_pc4_frozen", pc40, 32'h10);
    tick();
    chk("hold2_req0", 32'(req0), 32'd0);
    Stall = 0;
    tick();
    chk("release_pc4", pc40, 32'h14);
    chk("release_instr", instr0, memWord(32'h10));
    chk("release_addr", addr0, 32'h14);

    // Taken branch at IFID_PC4=0x20 with offset -2
    tick(); tick(); tick();
    chk("br_setup_pc4", pc40, 32'h20);
    Branch = 1; Zero = 1; BranchOffset = 32'hFFFF_FFFE;
    tick();
    chk("br_taken_addr", addr0, 32'h18);
    chk("br_taken_valid", 32'(valid0), 32'd0);
    Branch = 0; Zero = 0;
    tick(); tick();
    chk("br_nt_setup", pc40, 32'h20);
    Branch = 1; Zero = 0;
    tick();
    chk("br_nt_pc4", pc40, 32'h24);
    chk("br_nt_valid", 32'(valid0), 32'd1);

    // Branch up to 0x4000000C, fetch, then jump+branch while in HOLD
    Branch = 1; Zero = 1;
    BranchOffset = (32'h4000_000C - mPc4[0]) >> 2;
    tick();
    Branch = 0; Zero = 0; BranchOffset = 0;
    tick();
    chk("far_pc4", pc40, 32'h4000_0010);
    Stall = 1;
    tick();
    chk("far_hold_req", 32'(req0), 32'd0);
    J = 1; Branch = 1; Zero = 1; JumpIndex = 26'h000_0040;
    tick();
    chk("jmp_addr", addr0, 32'h4000_0100);
    chk("jmp_valid", 32'(valid0), 32'd0);
    chk("jmp_req", 32'(req0), 32'd1);
    J = 0; Branch = 0; Zero = 0; Stall = 0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      Stall        = ($urandom_range(0, 3) == 0);
      Branch       = 1'($urandom);
      Zero         = ($urandom_range(0, 7) == 0);
      J            = ($urandom_range(0, 15) == 0);
      imemReady    = ($urandom_range(0, 3) != 0);
      BranchOffset = 32'($urandom_range(0, 32)) - 32'd16;
      JumpIndex    = 26'($urandom);
      tick();
    end

    // Reset while waiting on memory
    rst_n = 1; Stall = 0; Branch = 0; Zero = 0; J = 0; imemReady = 1;
    tick(); tick(); tick();
    imemReady = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    chk("midwait_rst_addr1", addr1, 32'hFFFF_FFFC);
    chk("midwait_rst_valid1", 32'(valid1), 32'd0);
    chk("midwait_rst_addr0", addr0, 32'h0);
    rst_n = 1; imemReady = 1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded at reset (bits [1:0] must be 0).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port Stall, input, 1 bit, decode-stage hold request.
REQ-005 The block SHALL have port Branch, input, 1 bit, and port Zero, input, 1 bit; a taken branch is Branch&Zero.
REQ-006 The block SHALL have port J, input, 1 bit, jump request.
REQ-007 The block SHALL have port BranchOffset, input, 32 bits, sign-extended word offset.
REQ-008 The block SHALL have port JumpIndex, input, 26 bits, jump word index.
REQ-009 The block SHALL have ports imem_req (output, 1), imem_addr (output, 32), imem_rdata (input, 32) and imem_ready (input, 1), the instruction memory interface.
REQ-010 The block SHALL have ports IFID_Instr (output, 32), IFID_PC4 (output, 32), IFID_Valid (output, 1) and OP (output, 6, equal to IFID_Instr[31:26]), the IF/ID register feeding the control unit.

Function
REQ-011 The FSM SHALL have exactly three states: BOOT, FETCH and HOLD.
REQ-012 In BOOT, imem_req SHALL be 0 and the next state SHALL be FETCH unconditionally.
REQ-013 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC; the memory may see the address change while not ready, and imem_ready qualifies the current address only.
REQ-014 Redirect SHALL be J | (Branch&Zero); when both are set, J wins.
REQ-015 Jump target SHALL be {IFID_PC4[31:28], JumpIndex, 2'b00}.
REQ-016 Branch target SHALL be IFID_PC4 + (BranchOffset<<2), computed modulo 2^32.
REQ-017 Redirect SHALL take priority over Stall and over imem_ready in every state: PC<=target, IFID_Valid<=0, the holding buffer is discarded, next state FETCH.
REQ-018 In FETCH with ready=1, Stall=0 and no redirect: IFID_Instr<=imem_rdata, IFID_PC4<=PC+4, IFID_Valid<=1, PC<=PC+4.
REQ-019 In FETCH with ready=1, Stall=1 and no redirect: imem_rdata SHALL be captured into the holding buffer, the IF/ID register is unchanged, PC is unchanged, and the next state is HOLD.
REQ-020 In FETCH with ready=0, Stall=0 and no redirect: IFID_Valid<=0 (bubble) and PC is unchanged.
REQ-021 In FETCH with ready=0 and Stall=1: the IF/ID register and PC SHALL hold.
REQ-022 In HOLD, imem_req SHALL be 0; while Stall=1 all state holds; when Stall=0 the IF/ID register loads from the buffer with PC+4, IFID_Valid<=1, PC<=PC+4, and the next state is FETCH.
REQ-023 While Stall=1 and there is no redirect, IFID_Instr, IFID_PC4 and IFID_Valid SHALL hold their values.
REQ-024 PC+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-025 imem_addr[1:0] SHALL always be 2'b00.
REQ-026 Fetch-to-IF/ID latency SHALL be one cycle after the ready cycle; with zero-wait memory and no stalls, throughput SHALL be one instruction per cycle.

Reset
REQ-027 While rst_n=0 at a rising edge: PC<=RESET_PC, state<=BOOT, IFID_Instr<=0, IFID_PC4<=0, IFID_Valid<=0, holding buffer<=0; consequently OP=0, imem_req=0 and imem_addr=RESET_PC after the edge.
REQ-028 Reset SHALL override all other inputs, including mid-wait and mid-HOLD, and any pending instruction SHALL be discarded.

Verification
REQ-029 Release reset with zero-wait memory returning 0x20080005 at address 0 -> BOOT for 1 cycle, then IFID_Instr=0x20080005, IFID_PC4=4, OP=6'b001000, IFID_Valid=1; PC then steps 4, 8, 12 on consecutive cycles.
REQ-030 imem_ready low for 3 cycles at PC=8 -> 3 bubbles with IFID_Valid=0 and imem_addr held at 8, then the instruction from address 8 is delivered with IFID_PC4=12.
REQ-031 Stall=1 in the cycle the response for PC=0x10 arrives, held 2 cycles -> HOLD entered, imem_req=0 and the IF/ID register frozen; on release the buffered word is delivered with IFID_PC4=0x14 and no memory refetch occurs.
REQ-032 IFID_PC4=0x20 with Branch=1, Zero=1 and BranchOffset=-2 -> PC=0x18 and IFID_Valid=0 next cycle; the same inputs with Zero=0 -> sequential fetch continues.
REQ-033 IFID_PC4=0x4000_0010 with J=1, JumpIndex=0x0000040 and Branch=Zero=1 all in the same cycle, during HOLD with Stall=1 -> PC=0x4000_0100, buffer discarded, IFID_Valid=0, state FETCH.
REQ-034 RESET_PC=32'hFFFF_FFFC -> the first fetch gives IFID_PC4=0 and the next imem_addr=0; asserting rst_n=0 while waiting on ready -> imem_addr returns to RESET_PC and IFID_Valid=0.
